// File: rtl/mouse_click_if.sv
// Mouse signal bundle between the mouse controller and the click conditioner.
// master drives the raw inputs, slave produces the conditioned outputs.
interface mouse_click_if;
  logic        left_raw;
  logic [11:0] xpos_raw;
  logic [11:0] ypos_raw;
  logic        mouse_left;
  logic        mouse_click;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] click_xpos;
  logic [11:0] click_ypos;

  modport master (
    output left_raw, xpos_raw, ypos_raw,
    input  mouse_left, mouse_click,
    input  mouse_xpos, mouse_ypos,
    input  click_xpos, click_ypos
  );

  modport slave (
    input  left_raw, xpos_raw, ypos_raw,
    output mouse_left, mouse_click,
    output mouse_xpos, mouse_ypos,
    output click_xpos, click_ypos
  );
endinterface

// File: rtl/mouse_click_ctl.sv
// Left-button sync/debounce, cursor clamp and click capture
// for the 65 MHz pixel-clock domain.
module mouse_click_ctl #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int X_MAX           = 1023,
  parameter int Y_MAX           = 767
) (
  input  logic          clk,
  input  logic          rst,
  mouse_click_if.slave  mif
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]   XM      = 12'(X_MAX);
  localparam logic [11:0]   YM      = 12'(Y_MAX);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESS_W  = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_REL_W    = 2'd3;

  logic          sync1_q, sync1_d;
  logic          left_s_q, left_s_d;
  logic [11:0]   px_q, px_d;
  logic [11:0]   py_q, py_d;
  logic [11:0]   mx_q, mx_d;
  logic [11:0]   my_q, my_d;
  logic [11:0]   cx_q, cx_d;
  logic [11:0]   cy_q, cy_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          left_q, left_d;
  logic          click_q, click_d;

  always_comb begin
    sync1_d  = mif.left_raw;
    left_s_d = sync1_q;
    px_d     = mif.xpos_raw;
    py_d     = mif.ypos_raw;
    mx_d     = (px_q > XM) ? XM : px_q;
    my_d     = (py_q > YM) ? YM : py_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (left_s_q) begin
          state_d = S_PRESS_W;
          cnt_d   = '0;
        end
      end
      S_PRESS_W: begin
        if (!left_s_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_PRESSED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!left_s_q) begin
          state_d = S_REL_W;
          cnt_d   = '0;
        end
      end
      S_REL_W: begin
        if (left_s_q) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    left_d  = (state_d == S_PRESSED) || (state_d == S_REL_W);
    click_d = (state_q == S_PRESS_W) && (state_d == S_PRESSED);
    // Capture the same clamped value that lands on mouse_xpos/ypos.
    cx_d    = click_d ? mx_d : cx_q;
    cy_d    = click_d ? my_d : cy_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      left_s_q <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      click_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      left_s_q <= left_s_d;
      px_q     <= px_d;
      py_q     <= py_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      click_q  <= click_d;
    end
  end

  assign mif.mouse_left  = left_q;
  assign mif.mouse_click = click_q;
  assign mif.mouse_xpos  = mx_q;
  assign mif.mouse_ypos  = my_q;
  assign mif.click_xpos  = cx_q;
  assign mif.click_ypos  = cy_q;

endmodule

// File: doc/mouse_click_ctl.md
# mouse_click_ctl

Conditions raw mouse signals from the mouse controller before they reach the `buttonCtl` instances and the game-board logic. It synchronises and debounces the left button and clamps the cursor coordinates to the visible 1024x768 area. It also produces a one-cycle click pulse with the cursor position captured at the click. It sits between the mouse controller and every consumer of `mouse_left`, `mouse_xpos` and `mouse_ypos`, in the 65 MHz pixel-clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 65000: stable cycles required to accept a press or release; legal range 1..2^20; counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- `X_MAX`, 1023: largest legal x coordinate.
- `Y_MAX`, 767: largest legal y coordinate.

Ports:
- `clk` in 1: pixel clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low; one clock, no other reset.
- `left_raw` in 1: raw left button, asynchronous to `clk`.
- `xpos_raw` in 12: raw cursor x.
- `ypos_raw` in 12: raw cursor y.
- `mouse_left` out 1: debounced button level.
- `mouse_click` out 1: one-cycle pulse on an accepted press.
- `mouse_xpos` out 12: clamped, pipelined x.
- `mouse_ypos` out 12: clamped, pipelined y.
- `click_xpos` out 12: x captured at the last click.
- `click_ypos` out 12: y captured at the last click.

## Operation
- Input staging: `left_raw` passes through a 2-flop synchroniser, giving `left_s`. `xpos_raw` and `ypos_raw` pass through one register stage, giving `pos_s1`.
- Output position: `mouse_xpos <= min(pos_s1.x, X_MAX)` and `mouse_ypos <= min(pos_s1.y, Y_MAX)`. The comparison is unsigned on 12 bits.
- Because of this, position and `left_s` share the same 2-edge alignment.

FSM, with debounce counter `cnt`:
- IDLE: `mouse_left=0`. On `left_s=1`, go to PRESS_WAIT with `cnt=0`.
- PRESS_WAIT: `mouse_left=0`.
  - `left_s=0`: go to IDLE. This is a glitch; no click is produced.
  - Else, if `cnt==DEBOUNCE_CYCLES-1`: go to PRESSED, set `mouse_click=1` for one cycle, and load `click_xpos/ypos` with the same clamped value loaded into `mouse_xpos/ypos` at that edge.
  - Otherwise `cnt++`.
- PRESSED: `mouse_left=1`. On `left_s=0`, go to RELEASE_WAIT with `cnt=0`.
- RELEASE_WAIT: `mouse_left=1`.
  - `left_s=1`: go back to PRESSED. No new click is produced.
  - Else, if `cnt==DEBOUNCE_CYCLES-1`: go to IDLE.
  - Otherwise `cnt++`.

Output rules:
- `mouse_left` and `mouse_click` are registered and decoded from the next state.
- `mouse_click` is never high two cycles in a row. It is high only on entry to PRESSED from PRESS_WAIT.
- `click_xpos/ypos` hold their value until the next click.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`. It does not wrap.

## Timing
- Reset, asserted at any time including mid-debounce:
  - State goes to IDLE and `cnt=0`.
  - All synchroniser and pipeline flops are cleared.
  - All outputs become 0.
  - No click is emitted for a press interrupted by reset.
  - After release, a held button is re-debounced from IDLE.
- Position latency: `mouse_xpos/ypos` reflect `xpos_raw/ypos_raw` 2 edges after sampling.
- Press latency: edge E0 is the first edge that samples `left_raw=1`, with the level held stable after it.
  - State enters PRESS_WAIT at E0+2.
  - `mouse_left` rises and `mouse_click` pulses after edge E0+2+`DEBOUNCE_CYCLES`.
  - Example: `DEBOUNCE_CYCLES=1` gives E0+3.
- Release latency: `mouse_left` falls after edge E0+2+`DEBOUNCE_CYCLES`, where E0 is the first edge sampling `left_raw=0`.
- A glitch on `left_s` shorter than `DEBOUNCE_CYCLES` cycles produces no change in `mouse_left` and no click.
- Clicks are distinguished by level changes only. Simultaneous movement and press is legal; the captured position is the one aligned with the accepting edge.

## Test plan
- Reset: hold `rst=0` for 5 cycles while `left_raw=1` and `xpos_raw=500` -> all outputs stay 0. After release with `DEBOUNCE_CYCLES=4`, the click occurs at E0+6.
- Clean press, `DEBOUNCE_CYCLES=4`, `xpos_raw=300`, `ypos_raw=200`, `left_raw` raised at E0 and held 20 cycles -> `mouse_click` is a single pulse after E0+6; `mouse_left=1` from the same edge; `click_xpos=300`, `click_ypos=200`. After release, `mouse_left` falls 6 edges later.
- Bounce: `left_raw` high for 2 cycles, low for 1, then high and held -> exactly one click. It is timed from the last rising sample plus 6 edges.
- Release bounce: while PRESSED, drop `left_raw` for 2 cycles and restore it -> `mouse_left` stays 1 and there is no second `mouse_click`.
- Clamp: `xpos_raw=4095`, `ypos_raw=800` -> `mouse_xpos=1023` and `mouse_ypos=767` after 2 edges. A click in this state latches `click_xpos=1023` and `click_ypos=767`.
- Reset mid-debounce: assert `rst=0` during PRESS_WAIT with `cnt=2` -> no click and outputs become 0 immediately. With `left_raw` held high after release, exactly one click occurs 6 edges after the first post-reset sample.
